// File: rtl/irq_controller_if.sv
// irq_controller_if: request/mask/control inputs and PC-mux/stack outputs of the vectored interrupt controller.
interface irq_controller_if #(
    parameter int NUM_IRQ  = 4,
    parameter int ID_W     = 2,
    parameter int PC_WIDTH = 10
);
    logic [NUM_IRQ-1:0]  irq;
    logic                mask_we;
    logic [NUM_IRQ-1:0]  mask_wd;
    logic                gie;
    logic                reti;
    logic [PC_WIDTH-1:0] pc_next;
    logic                int_take;
    logic [PC_WIDTH-1:0] int_vector;
    logic [PC_WIDTH-1:0] push_addr;
    logic                in_service;
    logic [ID_W-1:0]     active_id;
    logic [NUM_IRQ-1:0]  pending;
    modport slave (
        input  irq, mask_we, mask_wd, gie, reti, pc_next,
        output int_take, int_vector, push_addr, in_service, active_id, pending
    );
    modport master (
        output irq, mask_we, mask_wd, gie, reti, pc_next,
        input  int_take, int_vector, push_addr, in_service, active_id, pending
    );
endinterface

// File: rtl/irq_controller.sv
// irq_controller: synchronises IRQ lines, latches rising edges as pending and
// issues a one-cycle vectored take to the lowest eligible index; no nesting until reti.
module irq_controller #(
    parameter int                  NUM_IRQ    = 4,
    parameter int                  ID_W       = 2,
    parameter int                  PC_WIDTH   = 10,
    parameter logic [PC_WIDTH-1:0] VEC_BASE   = 'h3F0,
    parameter int                  VEC_STRIDE = 4
) (
    input logic              clk,
    input logic              reset,
    irq_controller_if.slave  irq_if
);
    typedef enum logic [1:0] {IDLE, TAKE, SERVICE} state_t;
    state_t              state_q;
    logic [NUM_IRQ-1:0]  s1_q, s2_q, s3_q, pending_q, pending_d, mask_q;
    logic [NUM_IRQ-1:0]  eligible, rise, clr;
    logic [ID_W-1:0]     winner, active_id_q;
    logic [PC_WIDTH-1:0] int_vector_q, vector_d;
    logic                int_take_q, in_service_q, take;
    always_comb begin
        eligible = pending_q & mask_q;
        rise     = s2_q & ~s3_q;
        winner   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (eligible[i]) winner = ID_W'(i);
        take      = state_q == IDLE && irq_if.gie && |eligible;
        clr       = take ? NUM_IRQ'(1) << winner : '0;
        // a fresh edge on the line being taken survives the clear
        pending_d = (pending_q & ~clr) | rise;
        vector_d  = VEC_BASE + PC_WIDTH'(VEC_STRIDE) * PC_WIDTH'(winner);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            int_take_q   <= 1'b0;
            int_vector_q <= '0;
            active_id_q  <= '0;
            in_service_q <= 1'b0;
        end else begin
            s1_q       <= irq_if.irq;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            pending_q  <= pending_d;
            int_take_q <= take;
            if (irq_if.mask_we) mask_q <= irq_if.mask_wd;
            case (state_q)
                IDLE: if (take) begin
                    state_q      <= TAKE;
                    active_id_q  <= winner;
                    int_vector_q <= vector_d;
                    in_service_q <= 1'b1;
                end
                TAKE: state_q <= SERVICE;
                SERVICE: if (irq_if.reti) begin
                    state_q      <= IDLE;
                    in_service_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign irq_if.int_take   = int_take_q;
    assign irq_if.int_vector = int_vector_q;
    assign irq_if.push_addr  = irq_if.pc_next;
    assign irq_if.in_service = in_service_q;
    assign irq_if.active_id  = active_id_q;
    assign irq_if.pending    = pending_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scenarios plus random traffic checked against an event-level model.
module tb_irq_controller;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    int   ntake;
    always #5 clk = ~clk;

    irq_controller_if #(.NUM_IRQ(4), .ID_W(2), .PC_WIDTH(10)) bus ();
    irq_controller dut (.clk(clk), .reset(reset), .irq_if(bus));

    // model: sample history of irq, pending/mask sets, service flag
    logic [3:0] hist[$];
    logic [3:0] m_pend, m_mask;
    logic       m_svc, m_take;
    logic [1:0] m_id;
    logic [9:0] m_vec;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist = '{4'h0, 4'h0, 4'h0, 4'h0};
        m_pend = '0; m_mask = '0; m_svc = 0; m_take = 0; m_id = '0; m_vec = '0;
    endtask

    task automatic model_edge();
        logic [3:0] elig, rise;
        int win;
        hist.push_back(bus.irq);
        if (hist.size() > 8) void'(hist.pop_front());
        // an irq line seen rising by the sampler becomes pending two edges later
        rise = hist[hist.size()-3] & ~hist[hist.size()-4];
        elig = m_pend & m_mask;
        win = -1;
        for (int i = 3; i >= 0; i--) if (elig[i]) win = i;
        if (!m_svc && bus.gie && win >= 0) begin
            m_take = 1; m_svc = 1; m_id = 2'(win);
            m_vec = 10'(32'h3F0 + win * 4);
            m_pend[win] = 1'b0;
        end else begin
            if (m_svc && !m_take && bus.reti) m_svc = 0;
            m_take = 0;
        end
        m_pend = m_pend | rise;
        if (bus.mask_we) m_mask = bus.mask_wd;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".take"}, 32'(bus.int_take), 32'(m_take));
        chk({tag, ".svc"}, 32'(bus.in_service), 32'(m_svc));
        chk({tag, ".pend"}, 32'(bus.pending), 32'(m_pend));
        chk({tag, ".id"}, 32'(bus.active_id), 32'(m_id));
        chk({tag, ".vec"}, 32'(bus.int_vector), 32'(m_vec));
        chk({tag, ".push"}, 32'(bus.push_addr), 32'(bus.pc_next));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
        if (bus.int_take) ntake++;
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        reset = 1;
        bus.irq = '0; bus.mask_we = 0; bus.mask_wd = '0; bus.gie = 0; bus.reti = 0; bus.pc_next = 10'h123;
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk); #1;
        reset = 0;

        // 1: isolated irq0
        bus.gie = 1; bus.mask_we = 1; bus.mask_wd = 4'b0001; tick("t1m");
        bus.mask_we = 0; bus.irq = 4'b0001; ticks("t1a", 3);
        bus.irq = 4'b0000; tick("t1b");
        chk("t1_take", 32'(bus.int_take), 1);
        chk("t1_vec", 32'(bus.int_vector), 32'h3F0);
        chk("t1_pend", 32'(bus.pending), 0);
        tick("t1c");
        chk("t1_pulse", 32'(bus.int_take), 0);
        bus.reti = 1; tick("t1r"); bus.reti = 0; tick("t1d");

        // 2: simultaneous irq1 and irq2
        bus.mask_we = 1; bus.mask_wd = 4'b1111; tick("t2m");
        bus.mask_we = 0; bus.irq = 4'b0110; ticks("t2a", 3);
        bus.irq = 4'b0000; tick("t2b");
        chk("t2_vec1", 32'(bus.int_vector), 32'h3F4);
        ticks("t2c", 2);
        bus.reti = 1; tick("t2r"); bus.reti = 0; tick("t2d");
        chk("t2_take2", 32'(bus.int_take), 1);
        chk("t2_vec2", 32'(bus.int_vector), 32'h3F8);
        tick("t2e"); bus.reti = 1; tick("t2r2"); bus.reti = 0;

        // 3: masked line stays pending, taken once unmasked
        bus.mask_we = 1; bus.mask_wd = 4'b0000; tick("t3m");
        bus.mask_we = 0; bus.irq = 4'b1000; ticks("t3a", 4);
        bus.irq = 4'b0000; tick("t3b");
        chk("t3_pend", 32'(bus.pending), 32'h8);
        bus.mask_we = 1; bus.mask_wd = 4'b1000; tick("t3u");
        bus.mask_we = 0; tick("t3t");
        chk("t3_take", 32'(bus.int_take), 1);
        chk("t3_vec", 32'(bus.int_vector), 32'h3FC);
        tick("t3c"); bus.reti = 1; tick("t3r"); bus.reti = 0;

        // 4: edge during service, return with gie=0
        bus.mask_we = 1; bus.mask_wd = 4'b0001; bus.irq = 4'b0001; tick("t4m");
        bus.mask_we = 0; ticks("t4a", 2);
        bus.irq = 4'b0000; ticks("t4b", 2);
        bus.irq = 4'b0001; ticks("t4c", 3);
        bus.irq = 4'b0000; bus.gie = 0; tick("t4d");
        bus.reti = 1; tick("t4r"); bus.reti = 0; ntake = 0; ticks("t4e", 3);
        chk("t4_notake", 32'(ntake), 0);
        chk("t4_pend", 32'(bus.pending), 1);
        bus.gie = 1; tick("t4g");
        chk("t4_take", 32'(bus.int_take), 1);
        tick("t4h"); bus.reti = 1; tick("t4r2"); bus.reti = 0;

        // 5: reti in idle, two edges before take
        bus.reti = 1; tick("t5r"); bus.reti = 0;
        chk("t5_idle", 32'(bus.in_service), 0);
        bus.gie = 0; bus.mask_we = 1; bus.mask_wd = 4'b0010; tick("t5m"); bus.mask_we = 0;
        bus.irq = 4'b0010; ticks("t5a", 3); bus.irq = 4'b0000; ticks("t5b", 3);
        bus.irq = 4'b0010; ticks("t5c", 3); bus.irq = 4'b0000; ticks("t5d", 3);
        ntake = 0; bus.gie = 1; ticks("t5e", 6);
        chk("t5_count", 32'(ntake), 1);
        bus.reti = 1; tick("t5r2"); bus.reti = 0;

        // 6: async reset during service with irq2 pending
        bus.mask_we = 1; bus.mask_wd = 4'b1111; bus.irq = 4'b0001; tick("t6m");
        bus.mask_we = 0; ticks("t6a", 2);
        bus.irq = 4'b0100; ticks("t6b", 3);
        bus.irq = 4'b0000; ticks("t6c", 2);
        chk("t6_pend", 32'(bus.pending), 32'h4);
        chk("t6_svc", 32'(bus.in_service), 1);
        #2 reset = 1;
        #1;
        chk("t6_rsvc", 32'(bus.in_service), 0);
        chk("t6_rpend", 32'(bus.pending), 0);
        chk("t6_rtake", 32'(bus.int_take), 0);
        model_reset();
        @(posedge clk); #1;
        reset = 0;
        ntake = 0; ticks("t6d", 4);
        bus.irq = 4'b0100; ticks("t6e", 4); bus.irq = 4'b0000; ticks("t6f", 3);
        chk("t6_notake", 32'(ntake), 0);
        chk("t6_mask0", 32'(bus.pending), 32'h4);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) bus.irq = 4'($urandom_range(0, 15));
            bus.mask_we = ($urandom_range(0, 7) == 0);
            bus.mask_wd = 4'($urandom_range(0, 15));
            bus.gie = ($urandom_range(0, 3) != 0);
            bus.reti = ($urandom_range(0, 3) == 0);
            bus.pc_next = 10'($urandom);
            tick("rnd");
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
